bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter sequencing NUM_REQ tristate drivers onto one shared
//  DATA_WIDTH data bus. Issues a one-hot data_en per driver and guarantees a
//  one-cycle all-off turnaround between owners, so two drivers never contend.
//  Sits between bus masters (ALU, memory, I/O) and their driver instances.
// PARAMETERS
//  NUM_REQ    4   number of requesters/drivers (2..8)
//  IDX_W      2   width of owner index (>= clog2(NUM_REQ))
//  BURST_MAX  8   max GRANT cycles per tenure (used only with BUS_ARB_TIMEOUT_EN)
// PORTS
//  clk       in   1        rising-edge clock
//  rst_      in   1        synchronous active-low reset
//  req       in   NUM_REQ  level request; held high while requester wants bus
//  gnt       out  NUM_REQ  one-hot grant, registered
//  data_en   out  NUM_REQ  one-hot driver enable to each driver's data_en
//  owner     out  IDX_W    index of current owner (valid when busy=1)
//  busy      out  1        1 while in GRANT
//  timeout   out  1        1-cycle pulse when a tenure is force-ended
// BEHAVIOUR
//  - Reset (rst_=0 at posedge): state=IDLE, gnt=0, data_en=0, owner=0,
//    busy=0, timeout=0, rr pointer=NUM_REQ-1 (so req[0] wins first).
//    Reset mid-tenure drops data_en on the same edge; no turnaround cycle.
//  - All outputs registered; data_en == gnt at all times.
//  - States: IDLE, GRANT, TURN.
//  - Arbitration (IDLE or TURN, any req set): winner = first set req[i]
//    scanning i = ptr+1, ptr+2, ... modulo NUM_REQ (wrap-around). Next edge:
//    gnt[winner]=1, owner=winner, ptr=winner, busy=1, state=GRANT.
//  - Latency: req seen at edge k in IDLE -> gnt/data_en high after edge k.
//  - IDLE, no req: stay IDLE, outputs 0.
//  - GRANT: hold while req[owner]=1 (other reqs ignored). When req[owner]=0
//    sampled: gnt=0, data_en=0, busy=0, state=TURN.
//  - TURN: exactly one cycle with all data_en=0 (bus floats to z). Arbitrate
//    as above -> GRANT, else -> IDLE. Sole requester may regain the bus after
//    TURN (pointer wraps back to itself).
//  - Requester dropping req during TURN/IDLE before grant: simply not chosen.
//  - req bits for indices >= NUM_REQ do not exist; no X propagation allowed.
// CONFIGURATION
//  BUS_ARB_TIMEOUT_EN defined: tenure counter (clog2(BURST_MAX+1) bits)
//   cleared on entry to GRANT, +1 per GRANT cycle. At edge where count reaches
//   BURST_MAX with req[owner] still 1: force -> TURN, timeout=1 for one cycle,
//   round-robin moves on (owner re-competes normally).
//  Not defined: no counter; tenure unbounded; timeout tied to 0.
// TESTING
//  1 Reset: rst_=0 two cycles, req=4'b1111 -> gnt=0, data_en=0, busy=0;
//    release -> gnt=4'b0001 one edge later, owner=0.
//  2 Round robin: req=4'b1111 held, each owner drops req 3 cycles then
//    re-raises -> grant order 0,1,2,3,0; TURN cycle data_en=0 between each.
//  3 Contention check: bench models 4 drivers (8'h11,8'h22,8'h33,8'h44)
//    on shared wire -> bus never X; equals 8'hzz in every TURN/IDLE cycle.
//  4 Sole requester: req=4'b0100 pulsed low 1 cycle -> GRANT, TURN, GRANT
//    to index 2 again; owner=2 throughout.
//  5 Reset mid-tenure: owner=1 busy, rst_=0 -> data_en=0 next edge, ptr=3;
//    after release with req=4'b0010 -> gnt=4'b0010.
//  6 (BUS_ARB_TIMEOUT_EN, BURST_MAX=8) req=4'b0011 held -> owner 0 for 8
//    cycles, timeout pulse, TURN, owner 1 for 8 cycles; undefined -> owner 0
//    holds indefinitely, timeout stays 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant and driver-enable bundle between bus_arbiter (master) and its requesters (slave).
interface bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] data_en;
  logic [IDX_W-1:0]   owner;
  logic               busy;
  logic               timeout;
  modport master (input req, output gnt, data_en, owner, busy, timeout);
  modport slave  (output req, input gnt, data_en, owner, busy, timeout);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of a shared tristate bus with a one-cycle all-off turnaround between tenures.
// Optional BUS_ARB_TIMEOUT_EN bounds each tenure to BURST_MAX cycles and pulses timeout when it is cut short.
module bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int BURST_MAX = 8
) (
  input logic           clk,
  input logic           rst_,
  bus_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   j;
  logic [NUM_REQ-1:0] gnt_q;
  logic               busy_q;
  logic               to_q;
  logic               found;
  logic               hit;
  assign bus.gnt     = gnt_q;
  assign bus.data_en = gnt_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = to_q;
  // Scan from farthest to nearest so the last hit is the first requester after ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (bus.req[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
  end
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(BURST_MAX + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst_ || state != GRANT) ? '0 : cnt + CW'(1);
  assign hit = state == GRANT && bus.req[owner_q] && cnt == CW'(BURST_MAX - 1);
`else
  logic unused_burst;
  assign unused_burst = BURST_MAX != 0;
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state   <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      to_q    <= 1'b0;
      ptr     <= IDX_W'(NUM_REQ - 1);
    end else begin
      to_q <= 1'b0;
      case (state)
        GRANT: if (hit || !bus.req[owner_q]) begin
          state  <= TURN;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          to_q   <= hit;
        end
        IDLE, TURN: if (found) begin
          state   <= GRANT;
          gnt_q   <= NUM_REQ'(1) << win;
          owner_q <= win;
          ptr     <= win;
          busy_q  <= 1'b1;
        end else begin
          state  <= IDLE;
          gnt_q  <= '0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
